// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction memory loader.
// The master drives in_byte/in_valid. The loader (slave) answers with in_ready.
interface imem_loader_if;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader and backing store for the fetch stage instruction RAM.
// A byte stream is packed little-endian into 32-bit words and written to a
// 2^ADDR_BITS-entry RAM. The RAM has a combinational read port that fetch indexes with pc[7:2].
// busy holds the core in reset while a load session runs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no session; waits for start (length 0 completes in place)
// S_RECV  | accepting stream bytes into word_q, byte_idx selects lane
// S_WRITE | single cycle: commit word_q to mem[waddr], then RECV or IDLE
module imem_loader #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS:0]   length,
    imem_loader_if.slave         s_bus,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS:0]   words_written
);

    localparam int                 DEPTH   = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] MAX_LEN = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] ONE     = (ADDR_BITS + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_BITS:0]     len_q;
    logic [ADDR_BITS-1:0]   waddr_q;
    logic [1:0]             byte_idx_q;
    logic [WIDTH-1:0]       word_q;
    logic [ADDR_BITS:0]     words_written_q;
    logic                   done_q;
    logic                   in_ready_c;
    logic                   busy_c;
    logic [ADDR_BITS:0]     clamp_len;
    logic                   last_word;
    logic                   byte_xfer;

    logic [WIDTH-1:0]       mem [DEPTH];

    // Lengths beyond the RAM depth are clamped so waddr never wraps in a session.
    assign clamp_len = (length > MAX_LEN) ? MAX_LEN : length;
    assign last_word = ((words_written_q + ONE) == len_q);
    assign byte_xfer = (state_q == S_RECV) && s_bus.in_valid;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/busy decode.
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && (clamp_len != '0)) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b1;
                if (s_bus.in_valid && (byte_idx_q == 2'd3)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy_c  = 1'b1;
                state_d = last_word ? S_IDLE : S_RECV;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Session bookkeeping and byte packing. A reset mid-session drops the partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q           <= '0;
            waddr_q         <= '0;
            byte_idx_q      <= '0;
            word_q          <= '0;
            words_written_q <= '0;
            done_q          <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q           <= clamp_len;
                        waddr_q         <= '0;
                        byte_idx_q      <= '0;
                        words_written_q <= '0;
                        // A zero-length session completes on the accepting edge.
                        done_q          <= (clamp_len == '0);
                    end
                end
                S_RECV: begin
                    if (byte_xfer) begin
                        word_q[{byte_idx_q, 3'b000} +: 8] <= s_bus.in_byte;
                        byte_idx_q                        <= byte_idx_q + 2'd1;
                    end
                end
                S_WRITE: begin
                    waddr_q         <= waddr_q + 1'b1;
                    words_written_q <= words_written_q + ONE;
                    if (last_word) begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    done_q <= done_q;
                end
            endcase
        end
    end

    // Instruction RAM write port. Reset leaves the contents alone.
    always_ff @(posedge clk) begin
        if (state_q == S_WRITE) begin
            mem[waddr_q] <= word_q;
        end
    end

    assign rd_data        = mem[rd_addr];
    assign s_bus.in_ready = in_ready_c;
    assign busy           = busy_c;
    assign done           = done_q;
    assign words_written  = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader. A transaction-level model runs beside the DUT and
// a compare process checks the DUT against it every cycle. Literal checks pin known words and timings.
`timescale 1ns/1ps
module tb_imem_loader;
    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic [6:0]  length  = '0;
    logic [5:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [6:0]  words_written;

    imem_loader_if bus();

    imem_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .length        (length),
        .s_bus         (bus),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int n_assert    = 0;
    int n_fail      = 0;
    int busy_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a session is a list of expected words. Bytes are collected four at a time.
    // A collected word is committed one cycle later at address = words committed so far.
    logic [31:0] exp_mem [64];
    bit          known   [64];
    bit          m_active = 1'b0;
    bit          m_pend   = 1'b0;
    bit          m_done   = 1'b0;
    int          m_len    = 0;
    int          m_words  = 0;
    int          m_nb     = 0;
    logic [7:0]  m_b [4];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_done   = 1'b0;
            m_words  = 0;
            m_nb     = 0;
        end else if (!m_active) begin
            if (start) begin
                m_len    = (int'(length) > 64) ? 64 : int'(length);
                m_words  = 0;
                m_nb     = 0;
                m_pend   = 1'b0;
                m_done   = (m_len == 0);
                m_active = (m_len != 0);
            end
        end else if (m_pend) begin
            exp_mem[m_words] = {m_b[3], m_b[2], m_b[1], m_b[0]};
            known[m_words]   = 1'b1;
            m_words++;
            m_pend = 1'b0;
            if (m_words == m_len) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else if (bus.in_valid) begin
            m_b[m_nb] = bus.in_byte;
            m_nb++;
            if (m_nb == 4) begin
                m_nb   = 0;
                m_pend = 1'b1;
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_active));
        check("in_ready", 32'(bus.in_ready), 32'(m_active && !m_pend));
        check("done", 32'(done), 32'(m_done));
        check("words_written", 32'(words_written), 32'(m_words));
        if (known[rd_addr]) check("rd_data", rd_data, exp_mem[rd_addr]);
        if (busy) busy_cycles++;
    end

    task automatic do_start(input logic [6:0] len);
        start  = 1'b1;
        length = len;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            n_assert++;
            n_fail++;
            $display("FAIL send_byte_timeout: in_ready low for %0d cycles, expected high", guard);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'hEE;
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'hEE;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 500) begin
            n_assert++;
            n_fail++;
            $display("FAIL wait_idle_timeout: busy still high after %0d cycles, expected low", guard);
        end
    endtask

    logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};

    initial begin
        bus.in_byte  = 8'h00;
        bus.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_words_written", 32'(words_written), 32'd0);
        #29 reset = 1'b1;
        @(posedge clk); #1;

        // Two-word program, in_valid held high.
        busy_cycles = 0;
        do_start(7'd2);
        foreach (prog[i]) send_byte(prog[i]);
        wait_idle();
        check("t1_busy_cycles", 32'(busy_cycles), 32'd10);
        check("t1_done", 32'(done), 32'd1);
        check("t1_words_written", 32'(words_written), 32'd2);
        rd_addr = 6'd1; #1;
        check("t1_mem1", rd_data, 32'h0020_0093);
        rd_addr = 6'd0; #1;
        check("t1_mem0", rd_data, 32'h0010_0013);

        // Back-to-back start, same stream with in_valid low every other cycle.
        do_start(7'd2);
        foreach (prog[i]) begin
            send_byte(prog[i]);
            idle_cycle();
        end
        wait_idle();
        check("t2_words_written", 32'(words_written), 32'd2);
        rd_addr = 6'd0; #1;
        check("t2_mem0", rd_data, 32'h0010_0013);
        rd_addr = 6'd1; #1;
        check("t2_mem1", rd_data, 32'h0020_0093);

        // Zero-length start: done on the accepting edge, busy never rises.
        busy_cycles = 0;
        do_start(7'd0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("t3_busy_cycles", 32'(busy_cycles), 32'd0);
        check("t3_mem1", rd_data, 32'h0020_0093);

        // Length 100 clamps to 64; incrementing byte pattern fills the RAM.
        do_start(7'd100);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        wait_idle();
        check("t4_words_written", 32'(words_written), 32'd64);
        check("t4_in_ready", 32'(bus.in_ready), 32'd0);
        check("t4_done", 32'(done), 32'd1);
        rd_addr = 6'd63; #1;
        check("t4_mem63", rd_data, 32'hFFFE_FDFC);
        rd_addr = 6'd2; #1;
        check("t4_mem2", rd_data, 32'h0B0A_0908);

        // Reset two bytes into word 2 of a 4-word load.
        do_start(7'd4);
        for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
        reset = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_words_written", 32'(words_written), 32'd0);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        rd_addr = 6'd0; #1;
        check("t5_mem0", rd_data, 32'hA3A2_A1A0);
        rd_addr = 6'd1; #1;
        check("t5_mem1", rd_data, 32'hA7A6_A5A4);
        rd_addr = 6'd2; #1;
        check("t5_mem2", rd_data, 32'h0B0A_0908);
        do_start(7'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_idle();
        rd_addr = 6'd0; #1;
        check("t5_reload_mem0", rd_data, 32'h4433_2211);
        check("t5_reload_words", 32'(words_written), 32'd1);

        // start while busy is ignored; the 3-word session runs to its end.
        do_start(7'd3);
        send_byte(8'h01);
        send_byte(8'h02);
        start  = 1'b1;
        length = 7'd1;
        send_byte(8'h03);
        start  = 1'b0;
        for (int i = 4; i <= 12; i++) send_byte(8'(i));
        wait_idle();
        check("t6_words_written", 32'(words_written), 32'd3);
        rd_addr = 6'd2; #1;
        check("t6_mem2", rd_data, 32'h0C0B_0A09);

        // Read-during-write at address 0: old word until the WRITE edge.
        rd_addr = 6'd0;
        do_start(7'd1);
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
        check("t7_before_write", rd_data, 32'h0403_0201);
        check("t7_busy_in_write", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("t7_after_write", rd_data, 32'hCAFE_F00D);
        check("t7_done", 32'(done), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
